control_ajuste: RTL and testbench
=================================

# control_ajuste

Button-handling and mode-sequencing controller for the digital clock. It synchronizes and debounces the two front-panel buttons and owns the 3-state display mode (run / set hours / set minutes). It emits single-cycle increment pulses, with auto-repeat, to the hour and minute counters. It also drives the counting enable and the blink masks for the display driver, and drops back to run mode after a period of inactivity.

## Interface
Parameters:
- DEB_CYC, 4, consecutive stable cycles required to accept a button level change (≥2)
- HOLD_CYC, 20, cycles from the initial inc pulse to the first auto-repeat pulse
- REP_CYC, 8, cycles between auto-repeat pulses
- TIMEOUT_CYC, 100, idle cycles in a set mode before returning to run
- BLINK_CYC, 10, cycles per blink half-period
- CW, 24, width of all internal counters; must hold the largest parameter

Ports:
- clock  in  1  system clock; sole clock, all state on rising edge
- reset  in  1  asynchronous, active-high; clears all state immediately
- btn_modo  in  1  raw mode button, asynchronous, active-high
- btn_inc  in  1  raw increment button, asynchronous, active-high
- modo  out  2  0 = run, 1 = set hours, 2 = set minutes; 3 never occurs
- inc_horas  out  1  one-cycle pulse: hours counter +1
- inc_minutos  out  1  one-cycle pulse: minutes counter +1
- run_en  out  1  1 when modo==0; time counters advance only then
- vis_horas  out  1  hour digits visible (0 = blanked)
- vis_minutos  out  1  minute digits visible

## Operation
- Each button passes through a 2-flop synchronizer, then a debouncer. The debounce counter increments every cycle in which the synced level differs from the debounced level and clears whenever they match. The debounced level flips on the DEB_CYC-th consecutive differing cycle, and the counter clears at the same time.
- A press event is a rising edge of a debounced level: debounced high while its previous-cycle copy is low. Releases generate no event.
- Mode press advances modo 0→1→2→0 and clears the timeout counter, repeat state and blink phase.
- Inc press in modo 1 or 2 asserts inc_horas (modo 1) or inc_minutos (modo 2) and arms auto-repeat. In modo 0 it is ignored.
- Auto-repeat while debounced inc stays high in the same set mode:
  - first extra pulse HOLD_CYC cycles after the initial pulse;
  - then one pulse every REP_CYC cycles;
  - stops on release.
- Mode change while inc is held stops repeat; a new press is required.
- Mode press and inc press on the same cycle: the mode press wins and the inc press is discarded. No increment pulse is issued in either the old or the new mode.
- Timeout in modo 1/2:
  - the counter increments every cycle and clears on any press event or repeat pulse;
  - on reaching TIMEOUT_CYC-1, modo←0 at the next edge;
  - the counter is held at 0 in modo 0.
- Blink: in modo 1/2 a phase bit toggles every BLINK_CYC cycles and resets to 1 (visible) on mode entry.
  - vis_horas = 0 only when modo==1 and phase==0; vis_minutos likewise for modo==2.
  - Both are 1 in modo 0.
- All outputs are registered except run_en, vis_horas and vis_minutos. These three are pure decodes of the registered modo and phase.

## Timing
- Reset values: modo=0, inc_horas=0, inc_minutos=0, run_en=1, vis_horas=1, vis_minutos=1. Synchronizers, debounced levels and all counters are 0; the blink phase is 1.
- Latency: if raw btn_modo is first sampled high at edge k and stays high, modo changes at edge k+DEB_CYC+2. inc pulses have the same latency and last exactly one cycle.
- Glitch rejection: a raw pulse shorter than DEB_CYC cycles (after sync) produces no event.
- Repeat pulses are spaced exactly HOLD_CYC cycles (first) then REP_CYC cycles (edge to edge of the pulse).
- inc_horas and inc_minutos are never high on the same cycle, and never high in modo 0.
- Timeout return to modo 0 happens exactly TIMEOUT_CYC edges after the last press/repeat or mode entry.
- Reset asserted mid-operation (during debounce, repeat or blink): all outputs reach their reset values immediately (asynchronous). The first event after deassert needs a full DEB_CYC+2 latency.

## Test plan
Default parameters, 1 cycle = 1 clock.
- Reset, then btn_modo high 10 cycles → modo 0→1 at edge DEB_CYC+2=6 after the first sample; no further change while held; after release plus a second press → modo=2; third press → modo=0.
- btn_modo glitch of 3 cycles → modo stays 0, no pulses.
- modo=1, btn_inc held 60 cycles → inc_horas pulses at t0, t0+20, t0+28, t0+36, t0+44, t0+52 (6 pulses); inc_minutos stays 0; vis_horas toggles every 10 cycles.
- modo=0, btn_inc pressed → no pulses, run_en=1, vis both 1.
- modo=2, idle → modo returns to 0 exactly 100 cycles after entry; an inc press at cycle 50 extends the return to 100 cycles after that pulse.
- Both buttons rise on the same cycle in modo 1 → modo=2, no inc pulse. Reset asserted during repeat → all outputs immediately at reset values.

Source files
------------

// File: rtl/control_ajuste.sv
// control_ajuste: debounced two-button controller sequencing run/set-hours/set-minutes
// with auto-repeat increments, inactivity timeout and blink masks.
module control_ajuste #(
  parameter int DEB_CYC     = 4,
  parameter int HOLD_CYC    = 20,
  parameter int REP_CYC     = 8,
  parameter int TIMEOUT_CYC = 100,
  parameter int BLINK_CYC   = 10,
  parameter int CW          = 24
) (
  input  logic       clock,
  input  logic       reset,
  input  logic       btn_modo,
  input  logic       btn_inc,
  output logic [1:0] modo,
  output logic       inc_horas,
  output logic       inc_minutos,
  output logic       run_en,
  output logic       vis_horas,
  output logic       vis_minutos
);
  typedef enum logic [1:0] {RUN = 2'd0, SET_H = 2'd1, SET_M = 2'd2} modo_t;
  logic [1:0] raw, press, level;
  assign raw = {btn_inc, btn_modo};
  for (genvar b = 0; b < 2; b++) begin : g_btn
    logic [1:0] sy;
    logic lvl, lvl_q;
    logic [CW-1:0] cnt;
    always_ff @(posedge clock or posedge reset)
      if (reset) begin
        sy <= 2'b00;
        lvl <= 1'b0;
        lvl_q <= 1'b0;
        cnt <= '0;
      end else begin
        sy <= {sy[0], raw[b]};
        lvl_q <= lvl;
        if (sy[1] == lvl) cnt <= '0;
        else if (cnt == CW'(DEB_CYC - 1)) begin
          lvl <= ~lvl;
          cnt <= '0;
        end else cnt <= cnt + 1'b1;
      end
    assign press[b] = lvl & ~lvl_q;
    assign level[b] = lvl;
  end
  modo_t st;
  logic rep_act, first, phase;
  logic [CW-1:0] rep_cnt, tmo, bcnt;
  logic rep_hit;
  // first repeat waits HOLD_CYC after the initial pulse, later ones REP_CYC
  assign rep_hit = rep_act && level[1] && rep_cnt == (first ? CW'(HOLD_CYC - 1) : CW'(REP_CYC - 1));
  always_ff @(posedge clock or posedge reset)
    if (reset) begin
      st <= RUN;
      inc_horas <= 1'b0;
      inc_minutos <= 1'b0;
      rep_act <= 1'b0;
      first <= 1'b0;
      rep_cnt <= '0;
      tmo <= '0;
      bcnt <= '0;
      phase <= 1'b1;
    end else begin
      inc_horas <= 1'b0;
      inc_minutos <= 1'b0;
      if (press[0] || st == RUN) begin
        if (press[0]) st <= st == RUN ? SET_H : st == SET_H ? SET_M : RUN;
        rep_act <= 1'b0;
        rep_cnt <= '0;
        tmo <= '0;
        bcnt <= '0;
        phase <= 1'b1;
      end else begin
        if (press[1] || rep_hit) begin
          inc_horas <= st == SET_H;
          inc_minutos <= st == SET_M;
          rep_act <= 1'b1;
          first <= press[1];
          rep_cnt <= '0;
          tmo <= '0;
        end else begin
          rep_act <= rep_act & level[1];
          rep_cnt <= rep_act ? rep_cnt + 1'b1 : '0;
          if (tmo == CW'(TIMEOUT_CYC - 1)) st <= RUN;
          tmo <= tmo == CW'(TIMEOUT_CYC - 1) ? '0 : tmo + 1'b1;
        end
        bcnt <= bcnt == CW'(BLINK_CYC - 1) ? '0 : bcnt + 1'b1;
        if (bcnt == CW'(BLINK_CYC - 1)) phase <= ~phase;
      end
    end
  assign modo = st;
  assign run_en = st == RUN;
  assign vis_horas = !(st == SET_H && !phase);
  assign vis_minutos = !(st == SET_M && !phase);
endmodule

// File: tb/tb_control_ajuste.sv
// tb_control_ajuste: directed-vector bench for control_ajuste at default parameters.
module tb_control_ajuste;
  logic clock, reset, btn_modo, btn_inc;
  logic [1:0] modo;
  logic inc_horas, inc_minutos, run_en, vis_horas, vis_minutos;
  int vectors = 0;
  int errs = 0;
  control_ajuste dut (
    .clock(clock), .reset(reset), .btn_modo(btn_modo), .btn_inc(btn_inc),
    .modo(modo), .inc_horas(inc_horas), .inc_minutos(inc_minutos),
    .run_en(run_en), .vis_horas(vis_horas), .vis_minutos(vis_minutos)
  );
  initial begin
    clock = 1'b0;
    forever #5 clock = ~clock;
  end
  task automatic tick(input int n = 1);
    repeat (n) @(posedge clock);
    #1;
  endtask
  task automatic chk(input string tag, input logic [3:0] obs, input logic [3:0] exp);
    vectors++;
    assert (obs === exp) else begin
      errs++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask
  task automatic chk_rst(input string tag);
    chk({tag, "_modo"}, {2'b00, modo}, 4'd0);
    chk({tag, "_ih"}, {3'b0, inc_horas}, 4'd0);
    chk({tag, "_im"}, {3'b0, inc_minutos}, 4'd0);
    chk({tag, "_run"}, {3'b0, run_en}, 4'd1);
    chk({tag, "_vh"}, {3'b0, vis_horas}, 4'd1);
    chk({tag, "_vm"}, {3'b0, vis_minutos}, 4'd1);
  endtask
  initial begin
    reset = 1'b1;
    btn_modo = 1'b0;
    btn_inc = 1'b0;
    tick(3);
    chk_rst("reset");
    reset = 1'b0;
    tick(2);
    // mode sequencing with exact press latency
    btn_modo = 1'b1;
    tick(6);
    chk("modo_pre", {2'b00, modo}, 4'd0);
    tick();
    chk("modo_1", {2'b00, modo}, 4'd1);
    chk("run_en_1", {3'b0, run_en}, 4'd0);
    chk("vis_h_1", {3'b0, vis_horas}, 4'd1);
    tick(3);
    chk("modo_held", {2'b00, modo}, 4'd1);
    btn_modo = 1'b0;
    tick(8);
    btn_modo = 1'b1;
    tick(7);
    chk("modo_2", {2'b00, modo}, 4'd2);
    btn_modo = 1'b0;
    tick(8);
    btn_modo = 1'b1;
    tick(7);
    chk("modo_0", {2'b00, modo}, 4'd0);
    btn_modo = 1'b0;
    tick(8);
    // short glitch is rejected
    btn_modo = 1'b1;
    tick(3);
    btn_modo = 1'b0;
    for (int i = 0; i < 10; i++) begin
      tick();
      chk("glitch_modo", {2'b00, modo}, 4'd0);
      chk("glitch_inc", {2'b00, inc_horas, inc_minutos}, 4'd0);
    end
    // hours auto-repeat and blink
    btn_modo = 1'b1;
    tick(7);
    chk("enter_h", {2'b00, modo}, 4'd1);
    btn_modo = 1'b0;
    btn_inc = 1'b1;
    tick(6);
    for (int i = 0; i < 60; i++) begin
      tick();
      chk("rep_ih", {3'b0, inc_horas}, (i == 0 || (i >= 20 && (i - 20) % 8 == 0)) ? 4'd1 : 4'd0);
      chk("rep_im", {3'b0, inc_minutos}, 4'd0);
      chk("blink_h", {3'b0, vis_horas}, (((i + 7) / 10) % 2 == 0) ? 4'd1 : 4'd0);
    end
    btn_inc = 1'b0;
    tick(20);
    // minutes mode idle timeout
    btn_modo = 1'b1;
    tick(7);
    chk("enter_m", {2'b00, modo}, 4'd2);
    chk("enter_m_vm", {3'b0, vis_minutos}, 4'd1);
    btn_modo = 1'b0;
    tick(10);
    chk("blink_m_vm", {3'b0, vis_minutos}, 4'd0);
    chk("blink_m_vh", {3'b0, vis_horas}, 4'd1);
    tick(89);
    chk("tmo_99", {2'b00, modo}, 4'd2);
    tick();
    chk_rst("tmo_100");
    // inc ignored in run mode
    btn_inc = 1'b1;
    for (int i = 0; i < 12; i++) begin
      tick();
      chk("run_inc", {2'b00, inc_horas, inc_minutos}, 4'd0);
      chk("run_flags", {1'b0, run_en, vis_horas, vis_minutos}, 4'b0111);
    end
    btn_inc = 1'b0;
    tick(10);
    // timeout extended by an inc pulse at cycle 50
    btn_modo = 1'b1;
    tick(7);
    btn_modo = 1'b0;
    tick(8);
    btn_modo = 1'b1;
    tick(7);
    chk("enter_m2", {2'b00, modo}, 4'd2);
    btn_modo = 1'b0;
    tick(43);
    btn_inc = 1'b1;
    tick(7);
    chk("ext_im", {3'b0, inc_minutos}, 4'd1);
    chk("ext_ih", {3'b0, inc_horas}, 4'd0);
    btn_inc = 1'b0;
    tick(99);
    chk("ext_99", {2'b00, modo}, 4'd2);
    tick();
    chk("ext_100", {2'b00, modo}, 4'd0);
    tick(5);
    // simultaneous presses: mode wins, no increment
    btn_modo = 1'b1;
    tick(7);
    chk("enter_h2", {2'b00, modo}, 4'd1);
    btn_modo = 1'b0;
    tick(8);
    btn_modo = 1'b1;
    btn_inc = 1'b1;
    for (int i = 0; i < 12; i++) begin
      tick();
      chk("both_inc", {2'b00, inc_horas, inc_minutos}, 4'd0);
      if (i == 6) chk("both_modo", {2'b00, modo}, 4'd2);
    end
    btn_modo = 1'b0;
    btn_inc = 1'b0;
    tick(10);
    // asynchronous reset during repeat
    btn_inc = 1'b1;
    tick(7);
    chk("pre_rst_im", {3'b0, inc_minutos}, 4'd1);
    tick(22);
    chk("pre_rst_modo", {2'b00, modo}, 4'd2);
    #2 reset = 1'b1;
    #1 chk_rst("async_rst");
    tick();
    reset = 1'b0;
    btn_inc = 1'b0;
    tick(8);
    btn_modo = 1'b1;
    tick(6);
    chk("post_rst_pre", {2'b00, modo}, 4'd0);
    tick();
    chk("post_rst_modo", {2'b00, modo}, 4'd1);
    btn_modo = 1'b0;
    tick(2);
    $display("== %0d vectors applied, %0d miscompares ==", vectors, errs);
    $finish;
  end
endmodule
